// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight destination writes between ID
// issue and WB retire, and stalls ID on load-use and pending-count overflow.
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                id_valid_i,
   input  logic [4:0]          id_rs1_i,
   input  logic [4:0]          id_rs2_i,
   input  logic                id_use_rs1_i,
   input  logic                id_use_rs2_i,
   input  logic                id_regwrite_i,
   input  logic [4:0]          id_rd_i,
   input  logic                id_is_load_i,
   input  logic                flush_i,
   input  logic                ld_done_i,
   input  logic [4:0]          ld_rd_i,
   input  logic                wb_regwrite_i,
   input  logic [4:0]          wb_rd_i,
   output logic                id_stall_o,
   output logic [NUM_REGS-1:0] pending_o,
   output logic                busy_o,
   output logic                err_o
);

   localparam logic [CNT_W-1:0] MAX_PEND = '1;

   logic [CNT_W-1:0]    r_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] r_late;
   logic                r_err;

   logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] w_late_nxt;
   logic                w_err_nxt;

   logic w_hz_src1, w_hz_src2, w_hz_ovf;
   logic w_issue, w_retire;

   // A late (load) producer blocks a reader unless its data arrives this cycle.
   assign w_hz_src1 = id_use_rs1_i && (id_rs1_i != 5'd0) && (r_cnt[id_rs1_i] != '0)
                      && r_late[id_rs1_i] && !(ld_done_i && (ld_rd_i == id_rs1_i));
   assign w_hz_src2 = id_use_rs2_i && (id_rs2_i != 5'd0) && (r_cnt[id_rs2_i] != '0)
                      && r_late[id_rs2_i] && !(ld_done_i && (ld_rd_i == id_rs2_i));

   // A saturated counter may still accept an issue when a retire frees a slot.
   assign w_retire  = wb_regwrite_i && (wb_rd_i != 5'd0);
   assign w_hz_ovf  = id_regwrite_i && (id_rd_i != 5'd0) && (r_cnt[id_rd_i] == MAX_PEND)
                      && !(w_retire && (wb_rd_i == id_rd_i));

   assign id_stall_o = id_valid_i && (w_hz_src1 || w_hz_src2 || w_hz_ovf);
   assign w_issue    = id_valid_i && !id_stall_o && !flush_i && id_regwrite_i
                       && (id_rd_i != 5'd0);

   // Per-register next count, producer latency flag and sticky underflow error.
   always_comb begin
      logic v_inc;
      logic v_dec;
      w_err_nxt  = r_err;
      w_late_nxt = r_late;
      v_inc      = 1'b0;
      v_dec      = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_cnt_nxt[r] = r_cnt[r];
         if (r == 0) begin
            w_cnt_nxt[r]  = '0;
            w_late_nxt[r] = 1'b0;
         end else begin
            v_inc = w_issue  && (id_rd_i == 5'(r));
            v_dec = w_retire && (wb_rd_i == 5'(r));
            if (v_dec && (r_cnt[r] == '0))
               w_err_nxt = 1'b1;
            if (v_inc && !v_dec)
               w_cnt_nxt[r] = r_cnt[r] + 1'b1;
            else if (v_dec && !v_inc && (r_cnt[r] != '0))
               w_cnt_nxt[r] = r_cnt[r] - 1'b1;
            if (v_inc)
               w_late_nxt[r] = id_is_load_i;
            else if (ld_done_i && (ld_rd_i == 5'(r)))
               w_late_nxt[r] = 1'b0;
            else if (w_cnt_nxt[r] == '0)
               w_late_nxt[r] = 1'b0;
         end
      end
   end

   // Scoreboard state register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int r = 0; r < NUM_REGS; r++)
            r_cnt[r] <= '0;
         r_late <= '0;
         r_err  <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++)
            r_cnt[r] <= w_cnt_nxt[r];
         r_late <= w_late_nxt;
         r_err  <= w_err_nxt;
      end
   end

   // Pending map decoded from the registered counters.
   always_comb begin
      pending_o = '0;
      for (int r = 1; r < NUM_REGS; r++)
         pending_o[r] = (r_cnt[r] != '0);
   end

   assign busy_o = |pending_o;
   assign err_o  = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a reference model.
module tb_reg_scoreboard;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        id_valid_i, id_use_rs1_i, id_use_rs2_i, id_regwrite_i, id_is_load_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, ld_rd_i, wb_rd_i;
   logic        flush_i, ld_done_i, wb_regwrite_i;
   logic        id_stall_o, busy_o, err_o;
   logic [31:0] pending_o;

   int n_chk  = 0;
   int n_fail = 0;

   int m_cnt  [32];
   bit m_late [32];
   bit m_err;

   always #5 clk_i = ~clk_i;

   reg_scoreboard dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .id_regwrite_i(id_regwrite_i), .id_rd_i(id_rd_i), .id_is_load_i(id_is_load_i),
      .flush_i(flush_i), .ld_done_i(ld_done_i), .ld_rd_i(ld_rd_i),
      .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i),
      .id_stall_o(id_stall_o), .pending_o(pending_o), .busy_o(busy_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit src_blocks(input bit used, input int s);
      return used && s != 0 && m_cnt[s] > 0 && m_late[s] && !(ld_done_i && int'(ld_rd_i) == s);
   endfunction

   function automatic bit m_stall();
      bit ovf;
      if (!id_valid_i) return 1'b0;
      ovf = id_regwrite_i && id_rd_i != 0 && m_cnt[id_rd_i] == 3
            && !(wb_regwrite_i && wb_rd_i == id_rd_i);
      return src_blocks(id_use_rs1_i, int'(id_rs1_i)) ||
             src_blocks(id_use_rs2_i, int'(id_rs2_i)) || ovf;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 32; r++) begin
         m_cnt[r]  = 0;
         m_late[r] = 1'b0;
      end
      m_err = 1'b0;
   endtask

   task automatic m_update();
      bit iss, ret;
      int ird, wrd;
      iss = id_valid_i && !m_stall() && !flush_i && id_regwrite_i && id_rd_i != 0;
      ret = wb_regwrite_i && wb_rd_i != 0;
      ird = int'(id_rd_i);
      wrd = int'(wb_rd_i);
      if (ret && m_cnt[wrd] == 0) m_err = 1'b1;
      if (!(iss && ret && ird == wrd)) begin
         if (iss) m_cnt[ird] += 1;
         if (ret && m_cnt[wrd] > 0) m_cnt[wrd] -= 1;
      end
      if (ld_done_i && ld_rd_i != 0) m_late[ld_rd_i] = 1'b0;
      for (int r = 1; r < 32; r++)
         if (m_cnt[r] == 0) m_late[r] = 1'b0;
      if (iss) m_late[ird] = id_is_load_i;
   endtask

   task automatic clr();
      id_valid_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0; id_regwrite_i = 0;
      id_is_load_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
      flush_i = 0; ld_done_i = 0; ld_rd_i = 0; wb_regwrite_i = 0; wb_rd_i = 0;
   endtask

   task automatic settle(input string tag);
      logic [31:0] exp_pend;
      #1;
      exp_pend = '0;
      for (int r = 1; r < 32; r++) exp_pend[r] = (m_cnt[r] != 0);
      chk({tag, "_stall"},   32'(id_stall_o), 32'(m_stall()));
      chk({tag, "_pending"}, pending_o,       exp_pend);
      chk({tag, "_busy"},    32'(busy_o),     32'(exp_pend != 0));
      chk({tag, "_err"},     32'(err_o),      32'(m_err));
   endtask

   task automatic adv();
      @(posedge clk_i);
      m_update();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      clr();
      rst_i = 1'b0;
      @(posedge clk_i);
      m_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic issue(input int rd, input bit ld);
      clr();
      id_valid_i = 1; id_regwrite_i = 1; id_rd_i = 5'(rd); id_is_load_i = ld;
   endtask

   task automatic retire(input int rd);
      clr();
      wb_regwrite_i = 1; wb_rd_i = 5'(rd);
   endtask

   function automatic int pick(input bit need_late);
      int base;
      base = $urandom_range(1, 7);
      for (int k = 0; k < 7; k++) begin
         int r;
         r = (base + k - 1) % 7 + 1;
         if (m_cnt[r] > 0 && (!need_late || m_late[r])) return r;
      end
      return 0;
   endfunction

   initial begin
      clr();
      rst_i = 1'b0;
      m_reset();
      do_reset();

      // reset state
      settle("rst");
      chk("rst_pend_const",  pending_o,        32'h0);
      chk("rst_busy_const",  32'(busy_o),      32'h0);
      chk("rst_err_const",   32'(err_o),       32'h0);
      chk("rst_stall_const", 32'(id_stall_o),  32'h0);
      adv();

      // ALU producer then consumer
      issue(5, 1'b0); settle("alu_iss"); adv();
      clr(); id_valid_i = 1; id_use_rs1_i = 1; id_rs1_i = 5'd5;
      settle("alu_use");
      chk("alu_nostall", 32'(id_stall_o),   32'h0);
      chk("alu_pend5",   32'(pending_o[5]), 32'h1);
      adv();
      retire(5); settle("alu_ret"); adv();
      clr(); settle("alu_after");
      chk("alu_pend5_clr", 32'(pending_o[5]), 32'h0);
      adv();

      // load-use stall until ld_done bypass
      issue(6, 1'b1); settle("ld_iss"); adv();
      for (int i = 0; i < 3; i++) begin
         clr(); id_valid_i = 1; id_use_rs2_i = 1; id_rs2_i = 5'd6;
         settle("ld_wait");
         chk("ld_stall", 32'(id_stall_o), 32'h1);
         adv();
      end
      clr(); id_valid_i = 1; id_use_rs2_i = 1; id_rs2_i = 5'd6;
      ld_done_i = 1; ld_rd_i = 5'd6;
      settle("ld_byp");
      chk("ld_bypass", 32'(id_stall_o), 32'h0);
      adv();
      clr(); id_valid_i = 1; id_use_rs1_i = 1; id_rs1_i = 5'd6;
      settle("ld_post");
      chk("ld_post_nostall", 32'(id_stall_o), 32'h0);
      adv();
      retire(6); settle("ld_ret"); adv();

      // overflow on x7
      for (int i = 0; i < 3; i++) begin
         issue(7, 1'b0); settle("ovf_fill"); adv();
      end
      issue(7, 1'b0); settle("ovf_full");
      chk("ovf_stall", 32'(id_stall_o), 32'h1);
      adv();
      issue(7, 1'b0); wb_regwrite_i = 1; wb_rd_i = 5'd7;
      settle("ovf_swap");
      chk("ovf_swap_nostall", 32'(id_stall_o), 32'h0);
      adv();
      for (int i = 0; i < 3; i++) begin
         retire(7); settle("ovf_drain");
         chk("ovf_drain_pend7", 32'(pending_o[7]), 32'h1);
         adv();
      end
      clr(); settle("ovf_empty");
      chk("ovf_pend7_clr", 32'(pending_o[7]), 32'h0);
      adv();

      // flush and x0
      issue(8, 1'b0); flush_i = 1; settle("flush"); adv();
      clr(); settle("flush_after");
      chk("flush_pend8", 32'(pending_o[8]), 32'h0);
      adv();
      issue(0, 1'b1); id_use_rs1_i = 1; id_rs1_i = 5'd0;
      settle("x0_iss");
      chk("x0_nostall", 32'(id_stall_o), 32'h0);
      adv();
      clr(); id_valid_i = 1; id_use_rs1_i = 1; id_rs1_i = 5'd0;
      settle("x0_use");
      chk("x0_pend0",  32'(pending_o[0]), 32'h0);
      chk("x0_stall",  32'(id_stall_o),   32'h0);
      chk("x0_allclr", pending_o,         32'h0);
      adv();

      // underflow is sticky
      retire(9); settle("uf_ret"); adv();
      for (int i = 0; i < 3; i++) begin
         clr(); settle("uf_hold");
         chk("uf_err",   32'(err_o),        32'h1);
         chk("uf_pend9", 32'(pending_o[9]), 32'h0);
         adv();
      end

      // randomized traffic against the model
      do_reset();
      clr(); settle("rst2");
      chk("rst2_err", 32'(err_o), 32'h0);
      adv();
      for (int c = 0; c < 3000; c++) begin
         int r;
         clr();
         id_valid_i    = ($urandom_range(0, 3) != 0);
         id_use_rs1_i  = $urandom_range(0, 1);
         id_use_rs2_i  = $urandom_range(0, 1);
         id_rs1_i      = 5'($urandom_range(0, 7));
         id_rs2_i      = 5'($urandom_range(0, 7));
         id_regwrite_i = ($urandom_range(0, 3) != 0);
         id_rd_i       = 5'($urandom_range(0, 7));
         id_is_load_i  = $urandom_range(0, 1);
         flush_i       = ($urandom_range(0, 7) == 0);
         ld_rd_i       = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) begin
            r = pick(1'b1);
            if (r != 0) begin
               ld_done_i = 1; ld_rd_i = 5'(r);
            end
         end
         if ($urandom_range(0, 1) == 0) begin
            r = pick(1'b0);
            if (r != 0) begin
               wb_regwrite_i = 1; wb_rd_i = 5'(r);
            end
         end
         settle("rnd");
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
